// File: rtl/game_onchip_ram_pipelined.sv
// Single-port Avalon-MM on-chip RAM slave used as the game's data/sprite
// scratch memory. Width and depth are configurable. Reads are pipelined with
// a readdatavalid strobe and a latency of 1 or 2 cycles. After reset the RAM
// can optionally zero every word, holding waitrequest until that finishes.
// Addresses at or above DEPTH never write, and reads there return zero.
module game_onchip_ram_pipelined #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 25600,
  parameter int ADDR_W         = 15,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clken,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W/8-1:0]   byteenable,
  input  logic [DATA_W-1:0]     writedata,
  output logic [DATA_W-1:0]     readdata,
  output logic                  readdatavalid,
  output logic                  waitrequest,
  output logic                  init_done
);

  localparam int LANES = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;
  localparam logic [0:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state;
  logic [IDX_W-1:0]  clr_addr;
  logic [IDX_W-1:0]  addr_idx;
  logic              in_range;
  logic              accept;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] mem_q;
  logic              rng1;
  logic              vld1;
  logic [DATA_W-1:0] rd1;
  logic              vld_q;

  // The index is only the low address bits. in_range blocks any access
  // beyond DEPTH, so an out-of-range address can never alias onto a real word.
  assign addr_idx = address[IDX_W-1:0];
  assign in_range = ({1'b0, address} < DEPTH_X);

  // Reads and writes are taken only in READY on an enabled cycle. A write
  // that arrives with a read wins, and the read is dropped.
  assign accept      = (state == ST_READY) && chipselect && (read || write) && clken;
  assign wr_acc      = accept && write;
  assign rd_acc      = accept && read && !write;
  assign waitrequest = (state != ST_READY) || !clken;
  assign init_done   = (state == ST_READY);

  // Memory array and its raw read register. There is no reset here so the
  // array maps onto block RAM. The clear sequence has priority over host writes.
  always_ff @(posedge clk) begin
    if (clken) begin
      if (state == ST_CLEAR) begin
        mem[clr_addr] <= '0;
      end else if (wr_acc && in_range) begin
        for (int i = 0; i < LANES; i++) begin
          if (byteenable[i]) begin
            mem[addr_idx][8*i +: 8] <= writedata[8*i +: 8];
          end
        end
      end
      if (rd_acc) begin
        mem_q <= mem[addr_idx];
      end
    end
  end

  // Clear sequencer and first read stage. Every bit freezes while clken is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_RESET;
      clr_addr <= '0;
      vld1     <= 1'b0;
      rng1     <= 1'b0;
    end else if (clken) begin
      if (state == ST_CLEAR) begin
        if (clr_addr == LAST_IDX) begin
          clr_addr <= '0;
          state    <= ST_READY;
        end else begin
          clr_addr <= clr_addr + 1'b1;
        end
      end
      vld1 <= rd_acc;
      if (rd_acc) begin
        rng1 <= in_range;
      end
    end
  end

  // rng1 clears on reset, so this stage reads zero after reset and after an
  // out-of-range read. Otherwise it holds the most recent read's data.
  assign rd1 = rng1 ? mem_q : '0;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic              vld2;
      logic [DATA_W-1:0] rd2;

      // Extra output register for latency 2. It loads only on a completing beat.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          vld2 <= 1'b0;
          rd2  <= '0;
        end else if (clken) begin
          vld2 <= vld1;
          if (vld1) begin
            rd2 <= rd1;
          end
        end
      end

      assign readdata = rd2;
      assign vld_q    = vld2;
    end else begin : g_lat1
      assign readdata = rd1;
      assign vld_q    = vld1;
    end
  endgenerate

  // A strobe held over a disabled cycle appears on the next enabled cycle.
  assign readdatavalid = vld_q && clken;

endmodule
